// File: rtl/decode_imm_ctrl.sv
// Decode-stage front end: 2-entry skid FIFO for fetched instructions, opcode
// classification of the head entry, redirect flush and a saturating stall counter.
module decode_imm_ctrl #(
    parameter int N     = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [1:0]       imm_sel,
    output logic             is_jal,
    output logic             is_rtype,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [N-1:0]     instr_mem [2];
    logic [PC_W-1:0]  pc_mem    [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             in_ready_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             push;
    logic             pop;

    assign out_valid = (count_reg != 2'd0);
    assign in_ready  = in_ready_reg;
    assign push      = in_valid & in_ready_reg & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_instr = instr_mem[rd_ptr_reg];
    assign out_pc    = pc_mem[rd_ptr_reg];
    assign stall_cnt = stall_cnt_reg;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    // Entries are cleared on reset so the head reads as zero after power-up.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    instr_mem[gi] <= in_instr;
                    pc_mem[gi]    <= in_pc;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b1;
        end else begin
            count_reg    <= count_next;
            // Registered ready: depends only on the next occupancy, never on out_ready directly.
            in_ready_reg <= (count_next < 2'd2);
            if (flush) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        imm_sel  = 2'd0;
        is_jal   = 1'b0;
        is_rtype = 1'b0;
        illegal  = 1'b0;
        if (out_valid) begin
            case (out_instr[6:0])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_sel = 2'd0;
                OPC_STORE:                                  imm_sel = 2'd1;
                OPC_BRANCH:                                 imm_sel = 2'd2;
                OPC_LUI, OPC_AUIPC:                         imm_sel = 2'd3;
                OPC_JAL:                                    is_jal   = 1'b1;
                OPC_OP:                                     is_rtype = 1'b1;
                default:                                    illegal  = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Directed bench for decode_imm_ctrl: reset, class sweep, back-pressure,
// streaming, flush, mid-stream reset and stall-counter saturation.
module tb_decode_imm_ctrl;

    localparam int N     = 32;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_instr;
    logic [PC_W-1:0]  out_pc;
    logic [1:0]       imm_sel;
    logic             is_jal;
    logic             is_rtype;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_imm_ctrl #(.N(N), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .imm_sel(imm_sel), .is_jal(is_jal), .is_rtype(is_rtype), .illegal(illegal),
        .stall_cnt(stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {instr, imm_sel, is_jal, is_rtype, illegal}
    logic [31:0] cls_instr [11] = '{32'h00A00093, 32'h00112023, 32'h00208463, 32'h123452B7,
                                    32'h008000EF, 32'h002081B3, 32'hFFFFFFFF, 32'h00000017,
                                    32'h00002003, 32'h00008067, 32'h00000073};
    logic [4:0]  cls_exp   [11] = '{5'b00_000, 5'b01_000, 5'b10_000, 5'b11_000,
                                    5'b00_100, 5'b00_010, 5'b00_001, 5'b11_000,
                                    5'b00_000, 5'b00_000, 5'b00_000};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        step();
        step();
        rst = 1'b0;
        check_eq("reset_in_ready", 32'(in_ready), 32'd1);
        check_eq("reset_out_valid", 32'(out_valid), 32'd0);
        check_eq("reset_imm_sel", 32'(imm_sel), 32'd0);
        check_eq("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check_eq("reset_out_instr", out_instr, 32'd0);

        // Class sweep: push, observe one cycle later, pop.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_instr = cls_instr[i]; in_pc = 32'h1000 + 32'(i * 4);
            step();
            in_valid = 1'b0;
            check_eq($sformatf("cls%0d_valid", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("cls%0d_instr", i), out_instr, cls_instr[i]);
            check_eq($sformatf("cls%0d_flags", i),
                     32'({imm_sel, is_jal, is_rtype, illegal}), 32'(cls_exp[i]));
            step();
        end
        check_eq("cls_drained", 32'(out_valid), 32'd0);
        check_eq("cls_no_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: three offered, two accepted.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100013; in_pc = 32'h100;
        step();
        check_eq("bp_ready_after1", 32'(in_ready), 32'd1);
        check_eq("bp_stall_after1", 32'(stall_cnt), 32'd0);
        in_instr = 32'h00200013; in_pc = 32'h104;
        step();
        check_eq("bp_ready_after2", 32'(in_ready), 32'd0);
        check_eq("bp_stall_after2", 32'(stall_cnt), 32'd1);
        in_instr = 32'h00300013; in_pc = 32'h108;
        step();
        in_valid = 1'b0;
        check_eq("bp_ready_full", 32'(in_ready), 32'd0);
        check_eq("bp_stall_3", 32'(stall_cnt), 32'd2);
        check_eq("bp_head_pc0", out_pc, 32'h100);
        out_ready = 1'b1;
        step();
        check_eq("bp_head_pc1", out_pc, 32'h104);
        check_eq("bp_head_instr1", out_instr, 32'h00200013);
        check_eq("bp_ready_back", 32'(in_ready), 32'd1);
        check_eq("bp_stall_hold", 32'(stall_cnt), 32'd2);
        step();
        check_eq("bp_drained", 32'(out_valid), 32'd0);

        // Steady stream: one in, one out per cycle, no drops.
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_instr = 32'h00000013 | (32'(i) << 20); in_pc = 32'h400 + 32'(i * 4);
            step();
            check_eq($sformatf("st%0d_pc", i), out_pc, 32'h400 + 32'(i * 4));
            check_eq($sformatf("st%0d_instr", i), out_instr, 32'h00000013 | (32'(i) << 20));
            check_eq($sformatf("st%0d_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check_eq("st_drained", 32'(out_valid), 32'd0);

        // Flush with a full buffer and a pending push.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00A00093; in_pc = 32'h200;
        step();
        in_pc = 32'h204;
        step();
        check_eq("fl_full_ready", 32'(in_ready), 32'd0);
        check_eq("fl_stall_pre", 32'(stall_cnt), 32'd3);
        flush = 1'b1; in_pc = 32'h208;
        step();
        check_eq("fl_valid", 32'(out_valid), 32'd0);
        check_eq("fl_ready", 32'(in_ready), 32'd1);
        check_eq("fl_stall_same", 32'(stall_cnt), 32'd3);
        // Flush at count 1 where the push would otherwise be accepted.
        flush = 1'b0; in_pc = 32'h300;
        step();
        flush = 1'b1; in_pc = 32'h304;
        step();
        check_eq("fl1_valid", 32'(out_valid), 32'd0);
        check_eq("fl1_stall", 32'(stall_cnt), 32'd3);
        flush = 1'b0; out_ready = 1'b1; in_pc = 32'h308;
        step();
        in_valid = 1'b0;
        check_eq("fl1_next_pc", out_pc, 32'h308);
        step();
        check_eq("fl1_drained", 32'(out_valid), 32'd0);

        // Reset mid-stream with a full buffer and flush asserted.
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h500;
        step();
        in_pc = 32'h504;
        step();
        check_eq("rs_pre_stall", 32'(stall_cnt), 32'd4);
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check_eq("rs_in_ready", 32'(in_ready), 32'd1);
        check_eq("rs_out_valid", 32'(out_valid), 32'd0);
        check_eq("rs_stall", 32'(stall_cnt), 32'd0);
        check_eq("rs_out_pc", out_pc, 32'd0);
        check_eq("rs_flags", 32'({imm_sel, is_jal, is_rtype, illegal}), 32'd0);

        // Stall counter saturates at all-ones.
        in_valid = 1'b1; in_pc = 32'h600;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_stall", 32'(stall_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_imm_ctrl.md
Name: decode_imm_ctrl

Overview:
Decode-stage front-end controller for the RV32 pipeline. It accepts fetched instructions through a valid/ready handshake and buffers them in a 2-entry skid FIFO. For the head entry it classifies the opcode and presents instr, pc, the 2-bit immediate-format select for the decode immediate generator, and instruction-class flags to execute. It also owns decode-stage flush on redirect and keeps a stall-cycle counter for perf.

Parameters:
N, 32, datapath/instruction width
PC_W, 32, program-counter width
CNT_W, 16, stall counter width (saturating)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  branch/jump redirect; kill all buffered entries this cycle
in_valid  in  1  fetch presents instruction
in_ready  out  1  controller can accept (registered)
in_instr  in  N  fetched instruction
in_pc  in  PC_W  PC of in_instr
out_valid  out  1  head entry valid to execute
out_ready  in  1  execute consumes head this cycle
out_instr  out  N  head instruction (feeds immediate generator instr)
out_pc  out  PC_W  head PC
imm_sel  out  2  0=I, 1=S, 2=B, 3=U (immediate generator select)
is_jal  out  1  head is JAL (J-format immediate built in execute; imm_sel=0)
is_rtype  out  1  head is OP (no immediate used)
illegal  out  1  head opcode not in supported set
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst=1 at edge): both entries invalid, rd/wr pointers 0, in_ready=1, out_valid=0, stall_cnt=0. out_instr/out_pc=0, so imm_sel=0, is_jal=0, is_rtype=0, illegal=0. Reset overrides flush and all handshakes.
- Storage: 2 entries {instr, pc}, 1-bit wr_ptr/rd_ptr, 2-bit count (0..2).
- Push = in_valid & in_ready & ~flush. Pop = out_valid & out_ready & ~flush.
- in_ready registered: next in_ready = (next count < 2). It is 0 only when full; no combinational path from out_ready.
- out_valid = (count != 0). Head entry drives out_instr/out_pc combinationally from the rd_ptr entry.
- Latency: an instruction pushed at edge k is visible on out_* in cycle k+1.
- Simultaneous push and pop at count 1: count stays 1 and both pointers advance. At count 2 no push is possible. At count 0 no pop is possible; there is no bypass.
- Flush: count is set to 0 and pointers to 0 at the edge. A same-cycle push is dropped and a same-cycle pop is not counted as consumed. in_ready=1 the next cycle.
- Classification on opcode = out_instr[6:0]; outputs are combinational from the head entry:
  LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011 -> imm_sel=0
  STORE 0100011 -> imm_sel=1
  BRANCH 1100011 -> imm_sel=2
  LUI 0110111, AUIPC 0010111 -> imm_sel=3
  JAL 1101111 -> imm_sel=0, is_jal=1
  OP 0110011 -> imm_sel=0, is_rtype=1
  any other -> imm_sel=0, illegal=1
  All flags are 0 when out_valid=0, and imm_sel is forced to 0 in that case.
- Shift-immediate (OP-IMM funct3 001/101) zero-extension is the immediate generator's job; this controller selects only the I-format.
- stall_cnt increments by 1 on each edge with out_valid & ~out_ready & ~flush. It saturates at all-ones and is not cleared by flush.

Test Plan:
- Reset then idle: rst high 2 cycles, in_valid=0 -> in_ready=1, out_valid=0, imm_sel=0, stall_cnt=0.
- Class sweep: push 0x00A00093 (addi), 0x00112023 (sw), 0x00208463 (beq), 0x123452B7 (lui), 0x008000EF (jal), 0x002081B3 (add), 0xFFFFFFFF with out_ready=1 -> imm_sel 0,1,2,3,0,0,0 one cycle after each push; is_jal on jal only; is_rtype on add only; illegal on 0xFFFFFFFF only.
- Back-pressure: out_ready=0, push 3 back-to-back -> accepts 2, in_ready=0 from the cycle after the 2nd push. stall_cnt counts 1,2,3... Release out_ready -> entries drain in order with PCs preserved and in_ready reasserted.
- Steady stream: in_valid=1, out_ready=1, 8 instructions -> one output per cycle after 1-cycle latency, count stays ≤1, no drops or duplicates.
- Flush with full buffer plus same-cycle push -> next cycle out_valid=0, in_ready=1, dropped instruction never appears; stall_cnt unchanged by flush cycle.
- rst asserted mid-stream with count=2 and flush=1 -> all state cleared exactly as at power-up; stall_cnt=0.
